// File: rtl/fetch_unit.sv
// Dual-issue instruction fetch: owns the PC, issues one 64-bit read at a time,
// and forwards each returned pair with its PC and a discard flag to ID.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic [32:0] br_bus_i,
  input  logic        fifo_full_i,
  input  logic        stall_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [63:0] inst_rdata_i,
  output logic [33:0] if_to_id_bus_o,
  output logic [63:0] inst_rdata_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        cancel_q, cancel_d;
  logic        out_ce_q, out_ce_d;
  logic        out_disc_q, out_disc_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [63:0] out_data_q, out_data_d;

  logic        redirect;
  logic        stall;
  logic [31:0] target;

  assign redirect = flush_i | br_bus_i[32];
  assign target   = flush_i ? flush_pc_i : br_bus_i[31:0];
  assign stall    = stall_i | fifo_full_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    cancel_d   = cancel_q;
    out_ce_d   = 1'b0;
    out_disc_d = 1'b0;
    out_pc_d   = '0;
    out_data_d = '0;
    inst_req_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (!stall || redirect) state_d = REQ;
      end
      REQ: begin
        inst_req_o = 1'b1;
        if (inst_addr_ok_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd8;
          state_d  = WAIT;
          // The pair just accepted belongs to the old path.
          if (redirect) cancel_d = 1'b1;
        end else if (stall && !redirect) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (inst_data_ok_i) begin
          cancel_d = 1'b0;
          // A flush in the return cycle drops the pair; a branch keeps it as the delay slot.
          if (!flush_i) begin
            out_ce_d   = 1'b1;
            out_disc_d = cancel_q;
            out_pc_d   = req_pc_q;
            out_data_d = inst_rdata_i;
          end
          state_d = (!stall || redirect) ? REQ : IDLE;
        end else if (redirect) begin
          cancel_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect) pc_d = target;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      cancel_q   <= 1'b0;
      out_ce_q   <= 1'b0;
      out_disc_q <= 1'b0;
      out_pc_q   <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      cancel_q   <= cancel_d;
      out_ce_q   <= out_ce_d;
      out_disc_q <= out_disc_d;
      out_pc_q   <= out_pc_d;
      out_data_q <= out_data_d;
    end
  end

  assign inst_addr_o    = pc_q;
  assign if_to_id_bus_o = {out_disc_q, out_ce_q, out_pc_q};
  assign inst_rdata_o   = out_data_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-configurable memory plus a transaction-level
// scoreboard predicting request addresses, delivered pairs and discard flags.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic [32:0] br_bus_i;
  logic        fifo_full_i;
  logic        stall_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [63:0] inst_rdata_i;
  logic [33:0] if_to_id_bus_o;
  logic [63:0] inst_rdata_o;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .resetn(resetn), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .br_bus_i(br_bus_i), .fifo_full_i(fifo_full_i), .stall_i(stall_i),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_addr_ok_i(inst_addr_ok_i), .inst_data_ok_i(inst_data_ok_i),
    .inst_rdata_i(inst_rdata_i), .if_to_id_bus_o(if_to_id_bus_o),
    .inst_rdata_o(inst_rdata_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory and scoreboard state
  int          addr_lat = 0;
  int          data_lat = 1;
  int          req_wait = 0;
  bit          pend = 0;
  bit          pend_stale = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] exp_addr = RESET_PC;
  logic [31:0] acc_q[$];
  int          n_out = 0;
  logic [31:0] last_pc = '0;
  logic        last_disc = 1'b0;

  function automatic logic [63:0] memfn(input logic [31:0] a);
    return {(a + 32'd4) ^ 32'hA5A5_1234, a ^ 32'h1234_5A5A};
  endfunction

  task automatic cycle();
    bit          do_acc, do_data, redir, exp_out, exp_disc, rst_cyc, prev_wait, prev_redir;
    logic [31:0] tgt, exp_pc, prev_addr;
    logic [33:0] exp_bus;
    logic [63:0] exp_dat;
    do_acc = 0; do_data = 0; exp_out = 0; exp_disc = 0; exp_pc = '0;
    rst_cyc = !resetn;
    redir = flush_i | br_bus_i[32];
    tgt = flush_i ? flush_pc_i : br_bus_i[31:0];
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = '0;
    if (!rst_cyc) begin
      do_acc = inst_req_o && (req_wait >= addr_lat);
      if (pend) begin
        if (pend_cnt == 0) do_data = 1;
        else pend_cnt--;
      end
      inst_addr_ok_i = do_acc;
      inst_data_ok_i = do_data;
      if (do_data) inst_rdata_i = memfn(pend_addr);
      if (do_data) begin
        pend = 0;
        if (!flush_i) begin exp_out = 1; exp_pc = pend_addr; exp_disc = pend_stale; end
      end
      if (do_acc) begin
        checks++;
        if (inst_addr_o !== exp_addr) begin
          errors++;
          $display("FAIL req_addr: got %h want %h", inst_addr_o, exp_addr);
        end
        acc_q.push_back(inst_addr_o);
        pend = 1; pend_addr = exp_addr; pend_stale = redir; pend_cnt = data_lat - 1;
        exp_addr = redir ? tgt : exp_addr + 32'd8;
      end else if (redir) begin
        exp_addr = tgt;
        if (pend) pend_stale = 1;
      end
    end
    prev_wait = inst_req_o && !do_acc;
    prev_redir = redir;
    prev_addr = inst_addr_o;
    req_wait = (!rst_cyc && inst_req_o && !do_acc) ? req_wait + 1 : 0;
    if (rst_cyc) begin
      pend = 0; pend_stale = 0; exp_addr = RESET_PC; req_wait = 0;
    end
    @(posedge clk);
    #1;
    exp_bus = exp_out ? {exp_disc, 1'b1, exp_pc} : 34'd0;
    exp_dat = exp_out ? memfn(exp_pc) : 64'd0;
    checks++;
    if (if_to_id_bus_o !== exp_bus) begin
      errors++;
      $display("FAIL out_bus: got %h want %h", if_to_id_bus_o, exp_bus);
    end
    checks++;
    if (inst_rdata_o !== exp_dat) begin
      errors++;
      $display("FAIL out_data: got %h want %h", inst_rdata_o, exp_dat);
    end
    if (if_to_id_bus_o[32] === 1'b1) begin
      n_out++; last_pc = if_to_id_bus_o[31:0]; last_disc = if_to_id_bus_o[33];
    end
    if (!rst_cyc && inst_req_o) begin
      checks++;
      if (pend) begin
        errors++;
        $display("FAIL one_outstanding: req=1 while a pair is in flight");
      end
      if (prev_wait && !prev_redir) begin
        checks++;
        if (inst_addr_o !== prev_addr) begin
          errors++;
          $display("FAIL addr_stable: got %h want %h", inst_addr_o, prev_addr);
        end
      end
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cycle();
    cycle();
    acc_q.delete();
    n_out = 0;
    resetn = 1'b1;
  endtask

  task automatic clear_inputs();
    flush_i = 0; flush_pc_i = '0; br_bus_i = '0; fifo_full_i = 0; stall_i = 0;
    addr_lat = 0; data_lat = 1;
  endtask

  task automatic wait_acc(input int n, input int budget, input string nm);
    int k = 0;
    while (acc_q.size() < n && k < budget) begin cycle(); k++; end
    checks++;
    if (acc_q.size() < n) begin errors++; $display("FAIL %s_timeout: got %0d requests want %0d", nm, acc_q.size(), n); end
  endtask

  task automatic wait_out(input int n, input int budget, input string nm);
    int k = 0;
    while (n_out < n && k < budget) begin cycle(); k++; end
    checks++;
    if (n_out < n) begin errors++; $display("FAIL %s_timeout: got %0d outputs want %0d", nm, n_out, n); end
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    cycle();
    cycle();
    checks++;
    if (inst_req_o !== 1'b0 || inst_addr_o !== RESET_PC) begin
      errors++; $display("FAIL reset_state: req=%b addr=%h want req=0 addr=%h", inst_req_o, inst_addr_o, RESET_PC);
    end
    acc_q.delete(); n_out = 0;
    resetn = 1'b1;
    cycle();
    checks++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== RESET_PC) begin
      errors++; $display("FAIL first_req: req=%b addr=%h want req=1 addr=%h", inst_req_o, inst_addr_o, RESET_PC);
    end
  endtask

  task automatic test_stream();
    logic [31:0] want[3];
    want[0] = 32'hBFC0_0000; want[1] = 32'hBFC0_0008; want[2] = 32'hBFC0_0010;
    clear_inputs();
    do_reset();
    wait_out(3, 40, "stream");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= acc_q.size() || acc_q[i] !== want[i]) begin
        errors++; $display("FAIL stream_addr%0d: got %h want %h", i, (i < acc_q.size()) ? acc_q[i] : 32'hx, want[i]);
      end
    end
    checks++;
    if (last_pc !== want[2] || last_disc !== 1'b0) begin
      errors++; $display("FAIL stream_out: pc=%h disc=%b want pc=%h disc=0", last_pc, last_disc, want[2]);
    end
  endtask

  task automatic test_branch_wait();
    clear_inputs();
    data_lat = 3;
    do_reset();
    wait_acc(2, 30, "branch_acc");
    br_bus_i = {1'b1, 32'h8000_0100};
    cycle();
    br_bus_i = '0;
    wait_out(2, 20, "branch_out");
    checks++;
    if (last_pc !== 32'hBFC0_0008 || last_disc !== 1'b1) begin
      errors++; $display("FAIL branch_stale: pc=%h disc=%b want pc=bfc00008 disc=1", last_pc, last_disc);
    end
    wait_acc(3, 20, "branch_tgt");
    checks++;
    if (acc_q.size() < 3 || acc_q[2] !== 32'h8000_0100) begin
      errors++; $display("FAIL branch_target: got %h want 80000100", (acc_q.size() >= 3) ? acc_q[2] : 32'hx);
    end
    wait_out(3, 20, "branch_new");
    checks++;
    if (last_pc !== 32'h8000_0100 || last_disc !== 1'b0) begin
      errors++; $display("FAIL branch_new: pc=%h disc=%b want pc=80000100 disc=0", last_pc, last_disc);
    end
  endtask

  task automatic test_flush_data();
    clear_inputs();
    do_reset();
    wait_acc(2, 30, "flush_acc");
    flush_i = 1'b1; flush_pc_i = 32'hBFC0_0380;
    cycle();
    flush_i = 1'b0;
    checks++;
    if (if_to_id_bus_o[32] !== 1'b0 || n_out != 1) begin
      errors++; $display("FAIL flush_drop: ce=%b outputs=%0d want ce=0 outputs=1", if_to_id_bus_o[32], n_out);
    end
    wait_acc(3, 20, "flush_tgt");
    checks++;
    if (acc_q.size() < 3 || acc_q[2] !== 32'hBFC0_0380) begin
      errors++; $display("FAIL flush_target: got %h want bfc00380", (acc_q.size() >= 3) ? acc_q[2] : 32'hx);
    end
  endtask

  task automatic test_fifo_full();
    clear_inputs();
    fifo_full_i = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (inst_req_o !== 1'b0) begin errors++; $display("FAIL full_hold%0d: req=%b want 0", i, inst_req_o); end
    end
    fifo_full_i = 1'b0;
    cycle();
    checks++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== RESET_PC) begin
      errors++; $display("FAIL full_release: req=%b addr=%h want req=1 addr=%h", inst_req_o, inst_addr_o, RESET_PC);
    end
    fifo_full_i = 1'b1;
    do_reset();
    cycle();
    cycle();
    br_bus_i = {1'b1, 32'h9000_0040};
    cycle();
    br_bus_i = '0;
    checks++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== 32'h9000_0040) begin
      errors++; $display("FAIL full_branch: req=%b addr=%h want req=1 addr=90000040", inst_req_o, inst_addr_o);
    end
    for (int i = 0; i < 6; i++) cycle();
    checks++;
    if (n_out != 1 || last_pc !== 32'h9000_0040) begin
      errors++; $display("FAIL full_branch_out: outputs=%0d pc=%h want 1 at 90000040", n_out, last_pc);
    end
    fifo_full_i = 1'b0;
  endtask

  task automatic test_wrap();
    clear_inputs();
    do_reset();
    br_bus_i = {1'b1, 32'hFFFF_FFF8};
    cycle();
    br_bus_i = '0;
    wait_acc(2, 30, "wrap");
    checks++;
    if (acc_q.size() < 2 || acc_q[0] !== 32'hFFFF_FFF8 || acc_q[1] !== 32'h0) begin
      errors++; $display("FAIL wrap_addr: got %h,%h want fffffff8,00000000",
                         (acc_q.size() > 0) ? acc_q[0] : 32'hx, (acc_q.size() > 1) ? acc_q[1] : 32'hx);
    end
  endtask

  task automatic test_addr_delay();
    clear_inputs();
    addr_lat = 3;
    do_reset();
    wait_acc(1, 20, "delay_acc");
    stall_i = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    checks++;
    if (n_out != 1 || acc_q.size() != 1) begin
      errors++; $display("FAIL delay_count: outputs=%0d requests=%0d want 1 and 1", n_out, acc_q.size());
    end
    stall_i = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    clear_inputs();
    data_lat = 3;
    do_reset();
    wait_acc(1, 20, "rstwait_acc");
    cycle();
    resetn = 1'b0;
    cycle();
    checks++;
    if (inst_req_o !== 1'b0 || inst_addr_o !== RESET_PC || if_to_id_bus_o !== 34'd0 || inst_rdata_o !== 64'd0) begin
      errors++; $display("FAIL rstwait_zero: req=%b addr=%h bus=%h want 0/%h/0", inst_req_o, inst_addr_o, if_to_id_bus_o, RESET_PC);
    end
    acc_q.delete(); n_out = 0;
    resetn = 1'b1;
    cycle();
    checks++;
    if (inst_req_o !== 1'b1 || inst_addr_o !== RESET_PC) begin
      errors++; $display("FAIL rstwait_restart: req=%b addr=%h want req=1 addr=%h", inst_req_o, inst_addr_o, RESET_PC);
    end
    wait_out(1, 20, "rstwait_out");
    checks++;
    if (last_pc !== RESET_PC || last_disc !== 1'b0) begin
      errors++; $display("FAIL rstwait_out: pc=%h disc=%b want pc=%h disc=0", last_pc, last_disc, RESET_PC);
    end
  endtask

  task automatic test_random();
    clear_inputs();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      stall_i     = ($urandom_range(0, 7) == 0);
      fifo_full_i = ($urandom_range(0, 9) == 0);
      br_bus_i    = {($urandom_range(0, 11) == 0), $urandom() & 32'hFFFF_FFF8};
      flush_i     = ($urandom_range(0, 24) == 0);
      flush_pc_i  = $urandom() & 32'hFFFF_FFF8;
      if (i % 5 == 0) begin
        addr_lat = $urandom_range(0, 2);
        data_lat = $urandom_range(1, 3);
      end
      cycle();
    end
    clear_inputs();
    for (int i = 0; i < 10; i++) cycle();
    checks++;
    if (n_out < 100) begin
      errors++; $display("FAIL random_progress: outputs=%0d want at least 100", n_out);
    end
  endtask

  initial begin
    resetn = 1'b0;
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = '0;
    clear_inputs();
    test_reset();
    test_stream();
    test_branch_wait();
    test_flush_data();
    test_fifo_full();
    test_wrap();
    test_addr_delay();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
